pipeline_hazard_ctrl: RTL

- Sequences the five-stage RV32I pipeline registers: IFID, IDEX, EXMEM and MEMWB.
- Generates per-stage enable and bubble/flush controls from three events: data-memory wait states, taken branches/jumps, and load-use hazards.
- Contains a data-memory wait FSM with a timeout, plus stall and flush performance counters.
- Sits beside the datapath; the stage registers' en inputs and bubble/flush muxes are driven only by this block.

---
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enable/flush sequencing for a five-stage RV32I pipeline
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_en                   global run enable (debug hold)
//   i_dmem_req/ready       MEM-stage access request and same-cycle completion
//   i_branch_taken         EX resolved a taken branch/JAL/JALR
//   i_idex_mem_read/rd     load in EX and its destination register
//   i_ifid_rs1/rs2(_used)  source registers read by the instruction in ID
//   i_fault_clr            clears the sticky dmem timeout fault (works while i_en=0)
//   o_pc_en, o_*_en        PC and stage register enables
//   o_ifid_flush           IFID loads a NOP
//   o_idex_flush           IDEX loads a bubble
//   o_memwb_bubble         MEMWB captures register_write_enable=0
//   o_mem_fault            sticky dmem timeout flag
//   o_stall_cnt            frozen-PC cycle count (wraps)
//   o_flush_cnt            branch flush count (wraps)
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    input  logic             i_branch_taken,
    input  logic             i_idex_mem_read,
    input  logic [4:0]       i_idex_rd,
    input  logic [4:0]       i_ifid_rs1,
    input  logic [4:0]       i_ifid_rs2,
    input  logic             i_ifid_rs1_used,
    input  logic             i_ifid_rs2_used,
    input  logic             i_fault_clr,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_memwb_bubble,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_fault;
    logic             w_mstall;
    logic             w_lu;
    logic [7:0]       w_ctl;

    assign w_fault  = r_state == S_FAULT;
    assign w_mstall = i_dmem_req & ~i_dmem_ready & ~w_fault;
    assign w_lu     = i_idex_mem_read & (i_idex_rd != 5'd0) &
                      ((i_ifid_rs1_used & (i_ifid_rs1 == i_idex_rd)) |
                       (i_ifid_rs2_used & (i_ifid_rs2 == i_idex_rd)));

    // {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, memwb_bubble}
    always_comb begin
        w_ctl = (!i_en || w_fault) ? 8'b0000_0000 :
                w_mstall           ? 8'b0000_0011 :
                i_branch_taken     ? 8'b1111_1110 :
                w_lu               ? 8'b0001_1110 :
                                     8'b1101_0110;
    end

    assign {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en,
            o_idex_flush, o_exmem_en, o_memwb_en, o_memwb_bubble} = w_ctl & {8{i_rst_n}};
    assign o_mem_fault = i_rst_n & w_fault;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_fault) begin
            if (i_fault_clr) begin
                r_state    <= S_RUN;
                r_wait_cnt <= 8'd0;
            end
        end else if (i_en) begin
            if (!w_ctl[7])
                r_stall_cnt <= r_stall_cnt + 1'b1;
            // ifid_flush is asserted exactly on counted branch flushes
            if (w_ctl[5])
                r_flush_cnt <= r_flush_cnt + 1'b1;
            // wait_cnt is always 0 in RUN, so entry to DMEM_WAIT loads 1
            if (w_mstall) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                r_state    <= (r_wait_cnt == WAIT_LAST) ? S_FAULT : S_WAIT;
            end else begin
                r_wait_cnt <= 8'd0;
                r_state    <= S_RUN;
            end
        end
    end
endmodule
